// File: rtl/sejf_code_check_if.sv
// sejf_code_check_if -- dial/keypad side bundle of the combination checker.
//   master : the dial counter / operator side (drives digits and pulses)
//   slave  : the checker (drives status back)
// Signals:
//   bcd0, bcd1  units / tens digit of the current dial value
//   enter       one-cycle pulse, commit current dial value
//   close       one-cycle pulse, relock or abort entry
//   clr_count   one-cycle pulse, dial counter returns to 00
//   unlocked    high while the safe is open
//   err         one-cycle pulse on a wrong number
//   stage       numbers accepted so far (0..3)
//   fail_cnt    consecutive failed attempts, saturating at 3
//   locked_out  high during lockout
interface sejf_code_check_if;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic       enter;
    logic       close;
    logic       clr_count;
    logic       unlocked;
    logic       err;
    logic [1:0] stage;
    logic [1:0] fail_cnt;
    logic       locked_out;

    modport master (
        output bcd0, bcd1, enter, close,
        input  clr_count, unlocked, err, stage, fail_cnt, locked_out
    );

    modport slave (
        input  bcd0, bcd1, enter, close,
        output clr_count, unlocked, err, stage, fail_cnt, locked_out
    );
endinterface

// File: rtl/sejf_code_check.sv
// sejf_code_check -- three-number combination lock checker.
// The dial value {bcd1,bcd0} is compared against CODE0/CODE1/CODE2 on each
// enter pulse; three matches in a row open the safe. Every output is a flop.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  sejf_code_check_if.slave (digits, enter/close in; status out)
// Parameters: CODE0..CODE2 (BCD {tens,units}, 00..31), LOCKOUT_CYCLES (>=1).
// Build option: define SEJF_LOCKOUT_EN to add the LOCKOUT state; the third
// consecutive failure then freezes the lock for LOCKOUT_CYCLES cycles.
module sejf_code_check #(
    parameter logic [7:0] CODE0          = 8'h12,
    parameter logic [7:0] CODE1          = 8'h05,
    parameter logic [7:0] CODE2          = 8'h27,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    sejf_code_check_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, GOT1, GOT2, OPEN
`ifdef SEJF_LOCKOUT_EN
        , LOCKOUT
`endif
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] fail_cnt, fail_nxt, fail_inc;
    logic       clr_q, clr_nxt;
    logic       err_q, err_nxt;
    logic [1:0] stage_q;
    logic       unlocked_q;
    logic       locked_out_q;
    logic [7:0] dial, code_sel;
    logic       dial_ok, match;

`ifdef SEJF_LOCKOUT_EN
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [TW-1:0] timer, timer_nxt;
`else
    // Referenced only so the parameter stays part of the interface in this build.
    localparam int unused_lockout_cycles = LOCKOUT_CYCLES;
`endif

    function automatic logic [1:0] stage_of(state_t s);
        case (s)
            GOT1:    return 2'd1;
            GOT2:    return 2'd2;
            OPEN:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Out-of-range digits or values above 31 never match, even if a code
    // parameter happened to be set to such a value.
    assign dial    = {bus.bcd1, bus.bcd0};
    assign dial_ok = (bus.bcd0 <= 4'd9) && (bus.bcd1 <= 4'd3) &&
                     !((bus.bcd1 == 4'd3) && (bus.bcd0 > 4'd1));

    always_comb begin
        case (state)
            GOT1:    code_sel = CODE1;
            GOT2:    code_sel = CODE2;
            default: code_sel = CODE0;
        endcase
    end

    assign match    = dial_ok && (dial == code_sel);
    assign fail_inc = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        clr_nxt   = 1'b0;
        err_nxt   = 1'b0;
`ifdef SEJF_LOCKOUT_EN
        timer_nxt = timer;
`endif
        case (state)
`ifdef SEJF_LOCKOUT_EN
            LOCKOUT: begin
                // enter/close are deaf here; only the timer matters.
                if (timer == '0) begin
                    state_nxt = IDLE;
                    fail_nxt  = 2'd0;
                    clr_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
`endif
            OPEN: begin
                // enter is ignored while open; close relocks.
                if (bus.close) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end
            end
            default: begin
                // close has priority over a simultaneous enter.
                if (bus.close) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end else if (bus.enter) begin
                    clr_nxt = 1'b1;
                    if (match) begin
                        case (state)
                            IDLE:    state_nxt = GOT1;
                            GOT1:    state_nxt = GOT2;
                            default: begin
                                state_nxt = OPEN;
                                fail_nxt  = 2'd0;
                            end
                        endcase
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                        fail_nxt  = fail_inc;
`ifdef SEJF_LOCKOUT_EN
                        if (fail_inc == 2'd3) begin
                            state_nxt = LOCKOUT;
                            // Counts down to 0, so the lockout lasts exactly LOCKOUT_CYCLES.
                            timer_nxt = TW'(LOCKOUT_CYCLES - 1);
                        end
`endif
                    end
                end
            end
        endcase
    end

    // Status flops load from next-state so each output lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fail_cnt   <= 2'd0;
            clr_q      <= 1'b0;
            err_q      <= 1'b0;
            stage_q    <= 2'd0;
            unlocked_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            fail_cnt   <= fail_nxt;
            clr_q      <= clr_nxt;
            err_q      <= err_nxt;
            stage_q    <= stage_of(state_nxt);
            unlocked_q <= (state_nxt == OPEN);
        end
    end

`ifdef SEJF_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer        <= '0;
            locked_out_q <= 1'b0;
        end else begin
            timer        <= timer_nxt;
            locked_out_q <= (state_nxt == LOCKOUT);
        end
    end
`else
    assign locked_out_q = 1'b0;
`endif

    assign bus.clr_count  = clr_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.err        = err_q;
    assign bus.stage      = stage_q;
    assign bus.fail_cnt   = fail_cnt;
    assign bus.locked_out = locked_out_q;

endmodule

// File: tb/tb_sejf_code_check.sv
// Testbench for sejf_code_check: directed scenarios plus a randomized run
// checked against a cycle-level reference of the lock's rules.
// Observed vector layout: {clr_count, unlocked, err, stage[1:0], fail_cnt[1:0], locked_out}.
module tb_sejf_code_check;
    localparam int LC = 16;
`ifdef SEJF_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    sejf_code_check_if bus();

    sejf_code_check #(.LOCKOUT_CYCLES(LC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: numbers accepted, consecutive failures, remaining lockout cycles.
    int codes[3] = '{12, 5, 27};
    int m_stage, m_fail, m_lock;
    bit m_clr, m_err;

    function automatic logic [7:0] obs();
        return {bus.clr_count, bus.unlocked, bus.err, bus.stage, bus.fail_cnt, bus.locked_out};
    endfunction

    function automatic logic [7:0] expv();
        logic [7:0] v;
        v = {m_clr, (m_stage == 3), m_err, 2'(m_stage), 2'(m_fail), (m_lock > 0)};
        return v;
    endfunction

    task automatic model_edge(input bit e, input bit c, input int b1, input int b0);
        bit ok;
        int num;
        ok  = (b0 <= 9) && (b1 <= 3) && (b1 * 10 + b0 <= 31);
        num = b1 * 10 + b0;
        m_clr = 0;
        m_err = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_fail = 0;
                m_clr  = 1;
            end
        end else if (c) begin
            m_stage = 0;
            m_clr   = 1;
        end else if (e && m_stage < 3) begin
            m_clr = 1;
            if (ok && num == codes[m_stage]) begin
                m_stage++;
                if (m_stage == 3) m_fail = 0;
            end else begin
                m_stage = 0;
                m_err   = 1;
                if (m_fail < 3) m_fail++;
                if (LOCK_EN && m_fail == 3) m_lock = LC;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enter = 1'b0; bus.close = 1'b0; bus.bcd0 = 4'd0; bus.bcd1 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_stage = 0; m_fail = 0; m_lock = 0; m_clr = 0; m_err = 0;
    endtask

    // One clock: drive at negedge, clock in, update reference, settle 1 time unit.
    task automatic step(input bit e, input bit c, input logic [3:0] b1, input logic [3:0] b0);
        @(negedge clk);
        bus.enter = e; bus.close = c; bus.bcd1 = b1; bus.bcd0 = b0;
        @(posedge clk);
        model_edge(e, c, int'(b1), int'(b0));
        #1;
        bus.enter = 1'b0; bus.close = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] w;
        rst = 1'b1;
        #1;
        w = 8'b0;
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL reset_held: got %b want %b", obs(), w); end
        do_reset();
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL reset_release: got %b want %b", obs(), w); end
    endtask

    task automatic test_open_sequence();
        logic [7:0] w;
        do_reset();
        step(1, 0, 4'd1, 4'd2);
        w = {1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL open_first: got %b want %b", obs(), w); end
        step(0, 0, 4'd1, 4'd2);
        w = {1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL open_clr_one_cycle: got %b want %b", obs(), w); end
        step(1, 0, 4'd0, 4'd5);
        w = {1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL open_second: got %b want %b", obs(), w); end
        step(1, 0, 4'd2, 4'd7);
        w = {1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL open_third: got %b want %b", obs(), w); end
        step(1, 0, 4'd0, 4'd0);
        w = {1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL open_enter_ignored: got %b want %b", obs(), w); end
        step(0, 1, 4'd0, 4'd0);
        w = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL open_close: got %b want %b", obs(), w); end
    endtask

    task automatic test_wrong_number();
        logic [7:0] w;
        do_reset();
        step(1, 0, 4'd1, 4'd2);
        step(1, 0, 4'd0, 4'd6);
        w = {1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL wrong_second: got %b want %b", obs(), w); end
        step(0, 0, 4'd0, 4'd0);
        w = {1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL wrong_err_one_cycle: got %b want %b", obs(), w); end
    endtask

    task automatic test_invalid_bcd();
        logic [7:0] w;
        do_reset();
        step(1, 0, 4'hA, 4'd2);
        w = {1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL invalid_tens: got %b want %b", obs(), w); end
        // 32 is valid digit-wise but above the dial range.
        step(1, 0, 4'd3, 4'd2);
        w = {1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL invalid_32: got %b want %b", obs(), w); end
    endtask

    task automatic test_enter_close_same();
        logic [7:0] w;
        do_reset();
        step(1, 0, 4'd1, 4'd2);
        step(1, 0, 4'd0, 4'd5);
        step(1, 0, 4'd2, 4'd7);
        step(1, 1, 4'd1, 4'd2);
        w = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL both_in_open: got %b want %b", obs(), w); end
        // In GOT1 a matching enter must still lose to close; fail_cnt is kept.
        step(1, 0, 4'd0, 4'd0);
        step(1, 0, 4'd1, 4'd2);
        step(1, 1, 4'd0, 4'd5);
        w = {1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL both_in_got1: got %b want %b", obs(), w); end
    endtask

    task automatic test_lockout();
        logic [7:0] w;
        do_reset();
        step(1, 0, 4'd0, 4'd0);
        step(1, 0, 4'd0, 4'd0);
        step(1, 0, 4'd0, 4'd0);
        w = {1'b1, 1'b0, 1'b1, 2'd0, 2'd3, LOCK_EN};
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL lock_third_wrong: got %b want %b", obs(), w); end
        if (LOCK_EN) begin
            for (int i = 1; i < LC; i++) begin
                step(1, (i == 7), 4'd1, 4'd2);
                w = {1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b1};
                n_vec++;
                if (obs() !== w) begin n_err++; $display("FAIL lock_hold cyc%0d: got %b want %b", i, obs(), w); end
            end
            step(1, 0, 4'd1, 4'd2);
            w = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
            n_vec++;
            if (obs() !== w) begin n_err++; $display("FAIL lock_expire: got %b want %b", obs(), w); end
            step(1, 0, 4'd1, 4'd2);
            w = {1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
            n_vec++;
            if (obs() !== w) begin n_err++; $display("FAIL lock_after: got %b want %b", obs(), w); end
        end else begin
            step(1, 0, 4'd0, 4'd1);
            w = {1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0};
            n_vec++;
            if (obs() !== w) begin n_err++; $display("FAIL nolock_saturate: got %b want %b", obs(), w); end
            step(1, 0, 4'd1, 4'd2);
            step(1, 0, 4'd0, 4'd5);
            step(1, 0, 4'd2, 4'd7);
            w = {1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0};
            n_vec++;
            if (obs() !== w) begin n_err++; $display("FAIL nolock_open: got %b want %b", obs(), w); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        w = 8'b0;
        do_reset();
        step(1, 0, 4'd1, 4'd2);
        step(1, 0, 4'd0, 4'd5);
        #2 rst = 1'b1;   // mid-cycle, no clock edge before the check
        #1;
        n_vec++;
        if (obs() !== w) begin n_err++; $display("FAIL async_rst_got2: got %b want %b", obs(), w); end
        if (LOCK_EN) begin
            do_reset();
            repeat (3) step(1, 0, 4'd0, 4'd0);
            repeat (4) step(0, 0, 4'd0, 4'd0);
            #2 rst = 1'b1;
            #1;
            n_vec++;
            if (obs() !== w) begin n_err++; $display("FAIL async_rst_lockout: got %b want %b", obs(), w); end
        end
        do_reset();
    endtask

    task automatic test_random();
        bit e, c;
        logic [3:0] b1, b0;
        int idx;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0) begin
                idx = (m_stage < 3) ? m_stage : 0;
                b1  = 4'(codes[idx] / 10);
                b0  = 4'(codes[idx] % 10);
            end else begin
                b1 = 4'($urandom_range(0, 4));
                b0 = 4'($urandom_range(0, 15));
            end
            step(e, c, b1, b0);
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        bus.enter = 1'b0; bus.close = 1'b0; bus.bcd0 = 4'd0; bus.bcd1 = 4'd0;
        test_reset();
        test_open_sequence();
        test_wrong_number();
        test_invalid_bcd();
        test_enter_close_same();
        test_lockout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
